// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage stall encoding, exception flush with
// PC redirect, and stall-episode length tracking with a sticky timeout flag.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [4:0]  excp_type,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [7:0]  stall_cycles,
  output logic        stall_timeout
);

  localparam logic [4:0]  EXC_ERET    = 5'h0E;
  localparam logic [31:0] EXC_VECTOR  = 32'h0000_0020;
  localparam logic [7:0]  CYCLES_MAX  = 8'hFF;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t state, state_nxt;

  logic       any_req;
  logic       enter_flush;
  logic       count_en;
  logic [7:0] cycles_inc;

  assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN, STALL: begin
        if (excp_valid)   state_nxt = FLUSH;
        else if (any_req) state_nxt = STALL;
        else              state_nxt = RUN;
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Hold masks are contiguous from the PC upward, so the register just above
  // the highest held stage always takes a bubble.
  always_comb begin
    stall = '0;
    if (!excp_valid && state != FLUSH) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

  always_comb begin
    enter_flush = (state_nxt == FLUSH) && (state != FLUSH);
    count_en    = (state_nxt == STALL);
    cycles_inc  = (stall_cycles == CYCLES_MAX) ? CYCLES_MAX : stall_cycles + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush         <= 1'b0;
      new_pc        <= '0;
      stall_cycles  <= '0;
      stall_timeout <= 1'b0;
    end else begin
      flush <= enter_flush;
      if (enter_flush)
        new_pc <= (excp_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;
      stall_cycles <= count_en ? cycles_inc : '0;
      if (count_en && cycles_inc == CYCLES_MAX)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: behavioural model compared every
// cycle plus directed scenarios with literal expectations.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid;
  logic [4:0]  excp_type;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [7:0]  stall_cycles;
  logic        stall_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_type     (excp_type),
    .cp0_epc       (cp0_epc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flushing cycle, episode length, sticky timeout and redirect target.
  logic        m_flush;
  int          m_cnt;
  logic        m_timeout;
  logic [31:0] m_pc;

  function automatic logic [5:0] model_stall(input logic id, ex, mem, kill);
    int held;
    held = mem ? 5 : ex ? 4 : id ? 3 : 0;
    return kill ? 6'd0 : 6'((32'd1 << held) - 32'd1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flush = 1'b0; m_cnt = 0; m_timeout = 1'b0; m_pc = 32'h0;
    end else begin
      logic req;
      req = stallreq_id | stallreq_ex | stallreq_mem;
      m_cnt = (!m_flush && !excp_valid && req) ? ((m_cnt + 1 > 255) ? 255 : m_cnt + 1) : 0;
      if (m_cnt == 255) m_timeout = 1'b1;
      if (excp_valid && !m_flush)
        m_pc = (excp_type == 5'h0E) ? cp0_epc : 32'h0000_0020;
      m_flush = excp_valid && !m_flush;
    end
  end

  always @(negedge clk) begin
    check("stall", 32'(stall), 32'(model_stall(stallreq_id, stallreq_ex, stallreq_mem,
                                               excp_valid | m_flush)));
    check("flush", 32'(flush), 32'(m_flush));
    check("new_pc", new_pc, m_pc);
    check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    check("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
  end

  // Inputs change 2 time units after a rising edge.
  task automatic set_in(input logic id, ex, mem, ev, input logic [4:0] et, input logic [31:0] epc);
    stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excp_valid = ev; excp_type = et; cp0_epc = epc;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(2);
    check("rst_cycles", 32'(stall_cycles), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pc", new_pc, 32'h0);
    rst = 1'b0;
    tick(2);

    // Three-cycle EX stall
    for (int i = 1; i <= 3; i++) begin
      set_in(0, 1, 0, 0, 5'h0, 32'h0);
      tick(1);
      check("ex_stall", 32'(stall), 32'h0F);
      check("ex_cycles", 32'(stall_cycles), 32'(i));
    end
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(1);
    check("ex_release", 32'(stall_cycles), 32'd0);
    check("ex_release_stall", 32'(stall), 32'd0);

    // MEM+ID then drop MEM: re-encode without restarting count
    set_in(1, 0, 1, 0, 5'h0, 32'h0);
    tick(1);
    check("memid_stall", 32'(stall), 32'h1F);
    set_in(1, 0, 0, 0, 5'h0, 32'h0);
    #1 check("id_reencode", 32'(stall), 32'h07);
    tick(1);
    check("id_count_cont", 32'(stall_cycles), 32'd2);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(2);

    // Exception during MEM stall
    set_in(0, 0, 1, 0, 5'h0, 32'h0);
    tick(2);
    set_in(0, 0, 1, 1, 5'h0C, 32'h1234_5678);
    #1 check("excp_kill_stall", 32'(stall), 32'd0);
    tick(1);
    check("excp_flush", 32'(flush), 32'd1);
    check("excp_vector", new_pc, 32'h0000_0020);
    check("flush_cycles", 32'(stall_cycles), 32'd0);
    set_in(0, 0, 1, 0, 5'h0, 32'h0);
    #1 check("flush_kill_stall", 32'(stall), 32'd0);
    tick(1);
    check("post_flush", 32'(flush), 32'd0);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(2);

    // ERET, with a second exception held into the FLUSH cycle (ignored)
    set_in(0, 0, 0, 1, 5'h0E, 32'hBFC0_0100);
    tick(1);
    check("eret_flush", 32'(flush), 32'd1);
    check("eret_pc", new_pc, 32'hBFC0_0100);
    set_in(0, 0, 0, 1, 5'h0C, 32'h0);
    tick(1);
    check("flush_one_cycle", 32'(flush), 32'd0);
    check("pc_held", new_pc, 32'hBFC0_0100);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(2);

    // Long MEM stall saturates and sets the sticky timeout
    set_in(0, 0, 1, 0, 5'h0, 32'h0);
    tick(254);
    check("pre_timeout", 32'(stall_timeout), 32'd0);
    tick(1);
    check("timeout_set", 32'(stall_timeout), 32'd1);
    check("cycles_255", 32'(stall_cycles), 32'd255);
    tick(45);
    check("cycles_sat", 32'(stall_cycles), 32'd255);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(2);
    set_in(0, 0, 0, 1, 5'h02, 32'h0);
    tick(1);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(2);
    check("timeout_sticky", 32'(stall_timeout), 32'd1);

    // Async reset mid-stall
    set_in(0, 1, 0, 0, 5'h0, 32'h0);
    tick(40);
    check("cycles_40", 32'(stall_cycles), 32'd40);
    rst = 1'b1;
    #1;
    check("arst_cycles", 32'(stall_cycles), 32'd0);
    check("arst_timeout", 32'(stall_timeout), 32'd0);
    check("arst_flush", 32'(flush), 32'd0);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Reset during FLUSH: no pulse afterwards
    set_in(0, 0, 0, 1, 5'h0C, 32'h0);
    tick(1);
    set_in(0, 0, 0, 0, 5'h0, 32'h0);
    rst = 1'b1;
    #1 check("arst_in_flush", 32'(flush), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("no_flush_after_rst", 32'(flush), 32'd0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
